// File: rtl/alsu_pkg.sv
// Shared ALSU types: opcodes, the packed command word, driver FSM states and
// the illegal-command predicate used by both the driver and its bench.
package alsu_pkg;

  localparam int ALSU_TAG_W = 4;
  localparam int ALSU_OP_W  = 16;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e           opcode;
    logic signed [2:0] a;
    logic signed [2:0] b;
    logic              cin;
    logic              serial_in;
    logic              direction;
    logic              red_op_a;
    logic              red_op_b;
    logic              bypass_a;
    logic              bypass_b;
  } alsu_op_t;

  typedef struct packed {
    logic [ALSU_TAG_W-1:0] tag;
    logic                  clr;
    alsu_op_t              op;
  } alsu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } drv_state_e;

  // A clr command is never flagged: the ALSU is held in reset while it samples.
  function automatic logic is_invalid_cmd(input alsu_cmd_t c);
    logic red;
    red = c.op.red_op_a | c.op.red_op_b;
    return !c.clr && ((red && !(c.op.opcode inside {OR, XOR})) ||
                      (c.op.opcode inside {INVALID_6, INVALID_7}));
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of 2 (>= 2)
// so the pointers wrap by natural overflow.
module alsu_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/alsu_driver.sv
// ALSU initiator: queues command words, issues one at a time to the ALSU,
// waits out its pipeline latency and returns a tagged response.
module alsu_driver
  import alsu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALSU_LAT   = 2,
  parameter int TAG_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [TAG_W+16:0]       cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic signed [5:0]       rsp_out,
  output logic                    rsp_invalid,
  output logic                    rsp_leds_nz,
  output logic                    alsu_rst,
  output logic                    alsu_cin,
  output logic                    alsu_serial_in,
  output logic                    alsu_direction,
  output logic                    alsu_red_op_A,
  output logic                    alsu_red_op_B,
  output logic                    alsu_bypass_A,
  output logic                    alsu_bypass_B,
  output opcode_e                 alsu_opcode,
  output logic signed [2:0]       alsu_A,
  output logic signed [2:0]       alsu_B,
  input  logic signed [5:0]       alsu_out,
  input  logic [15:0]             alsu_leds
);

  localparam int CMD_W = TAG_W + 1 + ALSU_OP_W;
  localparam int CNT_W = (ALSU_LAT < 2) ? 1 : $clog2(ALSU_LAT + 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic [TAG_W-1:0] head_tag;
  logic             head_clr;
  alsu_op_t         head_op;
  alsu_cmd_t        head_cmd;

  drv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  alsu_op_t          drv_q, drv_d;
  logic              alsu_rst_q, alsu_rst_d;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic              cur_inv_q, cur_inv_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic signed [5:0] rsp_out_q, rsp_out_d;
  logic              rsp_invalid_q, rsp_invalid_d;
  logic              rsp_leds_nz_q, rsp_leds_nz_d;

  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

  alsu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (cmd_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_tag = fifo_rdata[CMD_W-1 -: TAG_W];
  assign head_clr = fifo_rdata[ALSU_OP_W];
  assign head_op  = alsu_op_t'(fifo_rdata[ALSU_OP_W-1:0]);

  // The tag plays no part in legality, so the predicate sees it as zero.
  always_comb begin
    head_cmd     = '0;
    head_cmd.clr = head_clr;
    head_cmd.op  = head_op;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drv_d         = drv_q;
    alsu_rst_d    = alsu_rst_q;
    cur_tag_d     = cur_tag_q;
    cur_inv_d     = cur_inv_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_out_d     = rsp_out_q;
    rsp_invalid_d = rsp_invalid_q;
    rsp_leds_nz_d = rsp_leds_nz_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          drv_d      = head_op;
          alsu_rst_d = head_clr;
          cnt_d      = CNT_W'(ALSU_LAT);
          cur_tag_d  = head_tag;
          cur_inv_d  = is_invalid_cmd(head_cmd);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alsu_rst_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // The ALSU output register holds the result by the time cnt hits 1.
        if (cnt_q == CNT_W'(1)) begin
          rsp_valid_d   = 1'b1;
          rsp_tag_d     = cur_tag_q;
          rsp_out_d     = alsu_out;
          rsp_invalid_d = cur_inv_q;
          rsp_leds_nz_d = |alsu_leds;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      drv_q         <= '0;
      alsu_rst_q    <= 1'b0;
      cur_tag_q     <= '0;
      cur_inv_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_out_q     <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_leds_nz_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drv_q         <= drv_d;
      alsu_rst_q    <= alsu_rst_d;
      cur_tag_q     <= cur_tag_d;
      cur_inv_q     <= cur_inv_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_out_q     <= rsp_out_d;
      rsp_invalid_q <= rsp_invalid_d;
      rsp_leds_nz_q <= rsp_leds_nz_d;
    end
  end

  // ALSU reset follows the system reset immediately, not a cycle late.
  assign alsu_rst       = rst | alsu_rst_q;
  assign alsu_opcode    = drv_q.opcode;
  assign alsu_A         = drv_q.a;
  assign alsu_B         = drv_q.b;
  assign alsu_cin       = drv_q.cin;
  assign alsu_serial_in = drv_q.serial_in;
  assign alsu_direction = drv_q.direction;
  assign alsu_red_op_A  = drv_q.red_op_a;
  assign alsu_red_op_B  = drv_q.red_op_b;
  assign alsu_bypass_A  = drv_q.bypass_a;
  assign alsu_bypass_B  = drv_q.bypass_b;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_out     = rsp_out_q;
  assign rsp_invalid = rsp_invalid_q;
  assign rsp_leds_nz = rsp_leds_nz_q;

endmodule

// File: tb/tb_alsu_driver.sv
// Directed bench for alsu_driver with a behavioural ALSU (FULL_ADDER on,
// input priority A) hanging off the alsu_* ports.
module tb_alsu_driver;
  import alsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [20:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_tag;
  logic [5:0]  rsp_out;
  logic        rsp_invalid, rsp_leds_nz;
  logic        alsu_rst, alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  opcode_e     alsu_opcode;
  logic [2:0]  alsu_A, alsu_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  int n_cmp = 0;
  int n_err = 0;
  int rst_hi_cnt = 0;

  always #5 clk = ~clk;

  alsu_driver #(.FIFO_DEPTH(4), .ALSU_LAT(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_out(rsp_out), .rsp_invalid(rsp_invalid), .rsp_leds_nz(rsp_leds_nz),
    .alsu_rst(alsu_rst), .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_direction(alsu_direction), .alsu_red_op_A(alsu_red_op_A),
    .alsu_red_op_B(alsu_red_op_B), .alsu_bypass_A(alsu_bypass_A),
    .alsu_bypass_B(alsu_bypass_B), .alsu_opcode(alsu_opcode),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_out(alsu_out), .alsu_leds(alsu_leds)
  );

  // Behavioural ALSU: input registers, then output/leds registers.
  logic signed [2:0] m_a, m_b;
  opcode_e           m_op;
  logic              m_cin, m_ser, m_dir, m_ra, m_rb, m_ba, m_bb;
  logic signed [5:0] m_out;
  logic [15:0]       m_leds;

  assign alsu_out  = m_out;
  assign alsu_leds = m_leds;

  always @(posedge clk) begin
    if (alsu_rst) begin
      m_a <= '0; m_b <= '0; m_op <= OR;
      m_cin <= 0; m_ser <= 0; m_dir <= 0; m_ra <= 0; m_rb <= 0; m_ba <= 0; m_bb <= 0;
      m_out <= '0; m_leds <= '0;
    end else begin
      m_a <= alsu_A; m_b <= alsu_B; m_op <= alsu_opcode;
      m_cin <= alsu_cin; m_ser <= alsu_serial_in; m_dir <= alsu_direction;
      m_ra <= alsu_red_op_A; m_rb <= alsu_red_op_B; m_ba <= alsu_bypass_A; m_bb <= alsu_bypass_B;
      if (((m_ra | m_rb) && m_op != OR && m_op != XOR) || m_op == INVALID_6 || m_op == INVALID_7) begin
        m_out  <= '0;
        m_leds <= ~m_leds;
      end else begin
        m_leds <= '0;
        if (m_ba) m_out <= 6'(m_a);
        else if (m_bb) m_out <= 6'(m_b);
        else begin
          case (m_op)
            OR: begin
              if (m_ra) m_out <= {5'b0, |m_a};
              else if (m_rb) m_out <= {5'b0, |m_b};
              else m_out <= 6'(m_a | m_b);
            end
            XOR: begin
              if (m_ra) m_out <= {5'b0, ^m_a};
              else if (m_rb) m_out <= {5'b0, ^m_b};
              else m_out <= 6'(m_a ^ m_b);
            end
            ADD:     m_out <= 6'(m_a) + 6'(m_b) + 6'(m_cin);
            MULT:    m_out <= 6'(m_a) * 6'(m_b);
            SHIFT:   m_out <= m_dir ? {m_out[4:0], m_ser} : {m_ser, m_out[5:1]};
            ROTATE:  m_out <= m_dir ? {m_out[4:0], m_out[5]} : {m_out[0], m_out[5:1]};
            default: m_out <= '0;
          endcase
        end
      end
    end
  end

  always @(negedge clk) if (alsu_rst) rst_hi_cnt <= rst_hi_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // flags = {cin, serial_in, direction, red_op_a}
  function automatic logic [20:0] mk(input logic [3:0] tag, input logic clr, input opcode_e op,
                                     input logic [2:0] a, input logic [2:0] b, input logic [3:0] flags);
    alsu_cmd_t c;
    c = '0;
    c.tag = tag; c.clr = clr; c.op.opcode = op; c.op.a = a; c.op.b = b;
    c.op.cin = flags[3]; c.op.serial_in = flags[2]; c.op.direction = flags[1]; c.op.red_op_a = flags[0];
    return c;
  endfunction

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic push(input logic [20:0] c);
    int n;
    cmd_valid = 1'b1;
    cmd_data  = c;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("push_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 64);
    check("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  int   cyc;
  logic seen;
  int   base;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
    check("rst_rsp_out",   32'(rsp_out),   32'd0);
    check("rst_alsu_rst",  32'(alsu_rst),  32'd1);
    check("rst_alsu_op",   32'(alsu_opcode), 32'd0);
    check("rst_alsu_a",    32'(alsu_A),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("alsu_rst_low", 32'(alsu_rst), 32'd0);

    check("fn_red_add", 32'(is_invalid_cmd(alsu_cmd_t'(mk(0, 0, ADD, 0, 0, 4'b0001)))), 32'd1);
    check("fn_clr_mask", 32'(is_invalid_cmd(alsu_cmd_t'(mk(0, 1, INVALID_7, 0, 0, 4'b0)))), 32'd0);
    check("fn_red_xor", 32'(is_invalid_cmd(alsu_cmd_t'(mk(0, 0, XOR, 0, 0, 4'b0001)))), 32'd0);

    // ADD 3+2+1: response 3 cycles after the pop, i.e. 4 negedges after push.
    push(mk(4'd1, 0, ADD, 3'd3, 3'd2, 4'b1000));
    wait_rsp(cyc);
    check("add_latency", 32'(cyc), 32'd4);
    check("add_tag", 32'(rsp_tag), 32'd1);
    check("add_out", 32'(rsp_out), 32'd6);
    check("add_inv", 32'(rsp_invalid), 32'd0);
    check("add_leds", 32'(rsp_leds_nz), 32'd0);
    check("add_hold_op", 32'(alsu_opcode), 32'(ADD));
    check("add_hold_a", 32'(alsu_A), 32'd3);

    push(mk(4'd2, 0, MULT, 3'b101, 3'd3, 4'b0));
    wait_rsp(cyc);
    check("mult_out", 32'(rsp_out), 32'b110111);
    check("mult_inv", 32'(rsp_invalid), 32'd0);

    push(mk(4'd3, 0, INVALID_6, 3'd1, 3'd1, 4'b0));
    wait_rsp(cyc);
    check("inv6_tag", 32'(rsp_tag), 32'd3);
    check("inv6_inv", 32'(rsp_invalid), 32'd1);
    check("inv6_out", 32'(rsp_out), 32'd0);
    check("inv6_leds", 32'(rsp_leds_nz), 32'd1);
    push(mk(4'd4, 0, OR, 3'b101, 3'd2, 4'b0001));
    wait_rsp(cyc);
    check("redor_inv", 32'(rsp_invalid), 32'd0);
    check("redor_out", 32'(rsp_out), 32'd1);
    check("redor_leds", 32'(rsp_leds_nz), 32'd0);

    // SHIFT left from 3, then a clr (illegal fields masked), then SHIFT from 0.
    push(mk(4'd5, 0, OR, 3'b011, 3'b001, 4'b0));
    wait_rsp(cyc);
    check("or_out", 32'(rsp_out), 32'b000011);
    push(mk(4'd6, 0, SHIFT, 3'd0, 3'd0, 4'b0110));
    wait_rsp(cyc);
    check("shift1_out", 32'(rsp_out), 32'b000111);
    base = rst_hi_cnt;
    push(mk(4'd7, 1, ADD, 3'd0, 3'd0, 4'b0001));
    wait_rsp(cyc);
    check("clr_tag", 32'(rsp_tag), 32'd7);
    check("clr_out", 32'(rsp_out), 32'd0);
    check("clr_inv", 32'(rsp_invalid), 32'd0);
    check("clr_pulse", 32'(rst_hi_cnt - base), 32'd1);
    push(mk(4'd8, 0, SHIFT, 3'd0, 3'd0, 4'b0110));
    wait_rsp(cyc);
    check("shift2_out", 32'(rsp_out), 32'b000001);
    @(negedge clk);

    // Backpressure: 1 in flight + 4 queued fills everything.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(mk(4'(i), 0, XOR, 3'(i), 3'd1, 4'b0));
    check("full_ready", 32'(cmd_ready), 32'd0);
    repeat (6) @(negedge clk);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_tag0", 32'(rsp_tag), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_hold_valid", 32'(rsp_valid), 32'd1);
    check("bp_hold_tag", 32'(rsp_tag), 32'd0);
    check("bp_still_full", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    push(mk(4'd5, 0, XOR, 3'd5, 3'd1, 4'b0));
    for (int i = 1; i < 6; i++) begin
      wait_rsp(cyc);
      check($sformatf("order_tag%0d", i), 32'(rsp_tag), 32'(i));
    end
    @(negedge clk);

    // Reset while WAITing with two commands queued.
    push(mk(4'd9, 0, ADD, 3'd1, 3'd1, 4'b0));
    push(mk(4'd10, 0, ADD, 3'd1, 3'd2, 4'b0));
    push(mk(4'd11, 0, ADD, 3'd1, 3'd3, 4'b0));
    rst = 1'b1;
    @(negedge clk);
    check("mid_alsu_rst", 32'(alsu_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_tag", 32'(rsp_tag), 32'd0);
    check("mid_rsp_out", 32'(rsp_out), 32'd0);
    check("mid_rsp_inv", 32'(rsp_invalid), 32'd0);
    check("mid_rsp_leds", 32'(rsp_leds_nz), 32'd0);
    check("mid_alsu_op", 32'(alsu_opcode), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alsu_driver.md
Name: alsu_driver

Overview:
- Hardware initiator for the ALSU: accepts packed command words on a valid/ready stream and buffers them in a 4-deep FIFO.
- Presents each command to the ALSU input ports, waits the ALSU pipeline latency, then captures out/leds.
- Returns one tagged response per command on a second valid/ready stream.
- Sits between a host/command source and the ALSU; it is the ALSU's only driver.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries (power of 2).
- ALSU_LAT, 2: ALSU input-register plus output-register latency in cycles.
- TAG_W, 4: width of the command/response tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  FIFO not full.
- cmd_data  in  TAG_W+17  packed alsu_cmd_t: {tag, clr, opcode[2:0], A[2:0], B[2:0], cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_tag  out  TAG_W  tag copied from the command.
- rsp_out  out  6  signed ALSU out captured at completion.
- rsp_invalid  out  1  command is illegal per ALSU rules (computed locally).
- rsp_leds_nz  out  1  captured leds != 0.
- alsu_rst, alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  ALSU control inputs.
- alsu_opcode  out  3  opcode_e to ALSU.
- alsu_A, alsu_B  out  3 each  signed operands to ALSU.
- alsu_out  in  6  ALSU result.
- alsu_leds  in  16  ALSU leds.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied; FSM to IDLE.
  - rsp_valid=0; rsp_tag, rsp_out, rsp_invalid, rsp_leds_nz = 0.
  - All alsu_* outputs 0, except alsu_rst, which is combinationally 1 while rst=1.
- All alsu_* outputs are registered. Between commands they hold the last issued values, so SHIFT/ROTATE state in the ALSU is not disturbed.
- FIFO:
  - push = cmd_valid & cmd_ready; pop occurs in IDLE when not empty.
  - Simultaneous push and pop when full is not allowed, because cmd_ready is based on full only.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO non-empty: pop head into the alsu_* registers; alsu_rst_q = clr; load wait counter = ALSU_LAT; go to ISSUE.
  - ISSUE (1 cycle): ALSU samples its inputs at the end of this cycle. Clear alsu_rst_q. Go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, capture alsu_out and |alsu_leds at that edge, assert rsp_valid, go to RESP.
  - Net timing: rsp_valid rises exactly ALSU_LAT+1 cycles after the pop edge.
  - RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On handshake, drop rsp_valid and go to IDLE. The next pop occurs no earlier than the following cycle.
- rsp_invalid = !clr & ((red_op_A|red_op_B) & opcode∉{OR,XOR} | opcode∈{INVALID_6,INVALID_7}), registered with the command.
- clr command:
  - alsu_rst is asserted for exactly the ISSUE cycle; other fields are driven as given.
  - The response is still produced; rsp_out is expected to be 0 and rsp_invalid=0.
- The FIFO keeps accepting commands during ISSUE/WAIT/RESP.
- Throughput: one command per ALSU_LAT+3 cycles with rsp_ready held high.
- rst mid-operation discards the in-flight command and all queued commands; no response is emitted for them.

Decomposition:
- Add to alsu_pkg:
  - alsu_cmd_t packed struct.
  - drv_state_e enum.
  - function is_invalid_cmd(alsu_cmd_t), reused by the bench scoreboard.
  - Reuse the existing opcode_e.
- One sub-module, alsu_cmd_fifo: parameterised synchronous FIFO with full/empty flags and the same clk/rst.

Test Plan:
- ADD, A=3, B=2, cin=1, ALU with FULL_ADDER="ON", rsp_ready=1 -> rsp_valid rises 3 cycles after the pop; rsp_out=6, rsp_invalid=0, rsp_leds_nz=0.
- MULTI, A=-3, B=3 -> rsp_out=-9 (6'b110111), rsp_invalid=0.
- opcode=INVALID_6, then OR with red_op_A=1 -> first response rsp_invalid=1, rsp_out=0, rsp_leds_nz=1; second response rsp_invalid=0, rsp_out=|A.
- rsp_ready=0 while 6 commands are pushed back-to-back -> cmd_ready drops after the 5th push (1 in flight + 4 queued). Releasing rsp_ready returns tags 0..5 in order.
- Push SHIFT, direction=1, serial_in=1 after OR out=6'b000011, then clr, then SHIFT -> responses 6'b000111, 0, then 6'b000001; alsu_rst high exactly one cycle.
- rst asserted during WAIT with 2 commands queued -> no rsp_valid afterwards, cmd_ready=1 the next cycle, all rsp_* read 0.
